// File: rtl/pll_reset_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the sequencer state encoding and the saturating status-counter helper.
package pll_reset_seq_pkg;

    localparam int STAT_W = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous status bit.
// Output follows d after STAGES clk edges; the chain clears to 0 on async reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: resets the PLL, qualifies lock, then releases sys_rst_n.
// Define PLL_RESET_SEQ_LOSS_COUNT_EN to build the RUN lock-loss counter.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic              sys_rst_n,
    output logic [STAT_W-1:0] retry_cnt,
    output logic [STAT_W-1:0] loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic             retry_inc;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // A lock seen in the same cycle as the timeout takes priority over the retry.
    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = S_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s)                state_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) state_nxt = S_PLL_RST;
            end
            default: state_nxt = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt + 1'b1;
            pll_rst   <= (state_nxt == S_PLL_RST);
            sys_rst_n <= (state_nxt == S_RUN);
            if (retry_inc) retry_cnt <= sat_inc(retry_cnt);
        end
    end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic loss_inc;

    assign loss_inc = (state == S_RUN) && !locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_inc) begin
            loss_cnt <= sat_inc(loss_cnt);
        end
    end
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomised scoreboard bench for pll_reset_seq with a duration-based reference model.
module tb_pll_reset_seq;

    localparam int SYNC  = 2;
    localparam int PRC   = 4;
    localparam int TO    = 32;
    localparam int STC   = 8;
    localparam int CW    = 6;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    typedef struct packed {
        logic       pr;
        logic       sr;
        logic [7:0] rc;
        logic [7:0] lc;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    obs_t exp_q[$];
    bit   hist[$];
    int   ph, age, m_retry, m_loss;
    int   edge_idx = -1;
    int   sys_rise_edge = -1;
    int   plen = 0;
    int   last_pulse_len = 0;
    logic prev_sys = 1'b0;

    pll_reset_seq #(
        .SYNC_STAGES    (SYNC),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (STC),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_out();
        obs_t o;
        o.pr = (ph == PH_RST);
        o.sr = (ph == PH_RUN);
        o.rc = 8'(m_retry);
        o.lc = (LOSS_ON != 0) ? 8'(m_loss) : 8'h00;
        return o;
    endfunction

    // Reference: each phase lasts a number of cycles; lock is seen SYNC edges late.
    always @(posedge clk) begin : mdl
        bit ls;
        int nph;
        if (!rst_n) begin
            ph = PH_RST; age = 0; m_retry = 0; m_loss = 0;
            hist.delete();
            edge_idx = -1;
        end else begin
            edge_idx++;
            ls = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
            hist.push_back(pll_locked);
            if (hist.size() > SYNC) void'(hist.pop_front());
            age++;
            nph = ph;
            if (ph == PH_RST) begin
                if (age == PRC) nph = PH_WAIT;
            end else if (ph == PH_WAIT) begin
                if (ls) nph = PH_STAB;
                else if (age == TO) begin
                    nph = PH_RST;
                    if (m_retry < 255) m_retry++;
                end
            end else if (ph == PH_STAB) begin
                if (!ls) nph = PH_WAIT;
                else if (age == STC) nph = PH_RUN;
            end else if (!ls) begin
                nph = PH_RST;
                if (m_loss < 255) m_loss++;
            end
            if (nph != ph) begin
                ph  = nph;
                age = 0;
            end
        end
        exp_q.push_back(model_out());
    end

    always @(negedge clk) begin : mon
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, sys_rst_n, retry_cnt, loss_cnt};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL scoreboard edge %0d: got pll_rst=%b sys_rst_n=%b retry=%0d loss=%0d, want pll_rst=%b sys_rst_n=%b retry=%0d loss=%0d",
                             edge_idx, a.pr, a.sr, a.rc, a.lc, e.pr, e.sr, e.rc, e.lc);
            end
        end
        if (rst_n && sys_rst_n && !prev_sys) sys_rise_edge = edge_idx;
        prev_sys = sys_rst_n;
        if (!rst_n) plen = 0;
        else if (pll_rst) plen++;
        else if (plen > 0) begin
            last_pulse_len = plen;
            plen = 0;
        end
    end

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a posedge; asserts reset mid-cycle.
    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_sys_rst_n", int'(sys_rst_n), 0);
        chk("async_retry", int'(retry_cnt), 0);
        chk("async_loss", int'(loss_cnt), 0);
        step(hold);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        step(3);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_rst_n", int'(sys_rst_n), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_loss", int'(loss_cnt), 0);
        #1;
        rst_n = 1'b1;

        // Normal bring-up: lock first sampled at edge 10.
        step(10);
        pll_locked = 1'b1;
        step(12);
        chk("bringup_sys_rise_edge", sys_rise_edge, 20);
        chk("bringup_pll_rst_len", last_pulse_len, PRC);
        chk("bringup_retry", int'(retry_cnt), 0);

        // Lock loss in RUN: drop sampled at edge E.
        step(5);
        pll_locked = 1'b0;
        step(2);
        chk("loss_sys_still_up", int'(sys_rst_n), 1);
        step(1);
        chk("loss_sys_down", int'(sys_rst_n), 0);
        chk("loss_pll_rst", int'(pll_rst), 1);
        chk("loss_cnt", int'(loss_cnt), LOSS_ON);

        // Timeout retries with lock held low.
        step(71);
        chk("retry_one", int'(retry_cnt), 1);
        step(1);
        chk("retry_two", int'(retry_cnt), 2);
        chk("retry_pll_rst", int'(pll_rst), 1);
        step(5);
        chk("retry_pll_rst_len", last_pulse_len, PRC);

        // Stability glitch: 5 cycles stable, 3-cycle drop, then full requalification.
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        step(9);
        chk("glitch_sys_held", int'(sys_rst_n), 0);
        step(2);
        chk("glitch_sys_release", int'(sys_rst_n), 1);

        // Async reset while running.
        step(3);
        async_reset(2);
        step(30);
        chk("restart_sys_up", int'(sys_rst_n), 1);

        // Random lock patterns with occasional async resets.
        for (int i = 0; i < 150; i++) begin
            pll_locked = 1'($urandom_range(0, 1));
            step($urandom_range(1, 60));
            if ($urandom_range(0, 19) == 0) async_reset($urandom_range(1, 3));
        end

        // Saturation: far more than 255 timeouts.
        pll_locked = 1'b0;
        step(300 * (TO + PRC) + 50);
        chk("retry_saturated", int'(retry_cnt), 255);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
